// File: rtl/adder_accumulator_ctrl.sv
// adder_accumulator_ctrl
// Sequencing stage in front of an external 32-bit combinational adder.
// Operand beats arrive on a valid/ready stream. Each accepted beat is fed to
// the adder together with the running accumulator, and the sum is registered
// back as the new accumulator. The last beat of a packet moves the block to a
// result-holding state. The packet total, operand count and a sticky overflow
// flag are presented there on a valid/ready result port.
//
// Optional build macro:
//   ACC_SAT_EN - when defined, a wrapping beat pins the accumulator at
//                all-ones instead of keeping the modular sum.
module adder_accumulator_ctrl #(
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [31:0]      i_data,
  input  logic             i_valid,
  input  logic             i_last,
  output logic             o_ready,
  output logic [31:0]      o_add_a,
  output logic [31:0]      o_add_b,
  input  logic [31:0]      i_add_sum,
  output logic [31:0]      o_result,
  output logic [CNT_W-1:0] o_count,
  output logic             o_ovf,
  output logic             o_valid,
  input  logic             i_ready
);

  typedef enum logic [0:0] {
    S_ACC = 1'b0,
    S_OUT = 1'b1
  } state_e;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e            state_q, state_d;
  logic [31:0]       acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovf_q, ovf_d;

  logic              ready_s;
  logic              beat_s;
  logic              wrap_s;
  logic [31:0]       acc_next_s;

  // Counter increment that sticks at all-ones instead of rolling over.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    if (&c) begin
      return c;
    end else begin
      return c + CNT_ONE;
    end
  endfunction

  // Handshake qualification; ready is a function of state and reset only.
  always_comb begin
    ready_s = i_rst_n && (state_q == S_ACC);
    beat_s  = i_valid && ready_s;
    // The adder has no carry-out, so an unsigned wrap shows as sum < acc.
    wrap_s  = beat_s && (i_add_sum < acc_q);
`ifdef ACC_SAT_EN
    if (wrap_s) begin
      acc_next_s = 32'hFFFF_FFFF;
    end else begin
      acc_next_s = i_add_sum;
    end
`else
    acc_next_s = i_add_sum;
`endif
  end

  // Next-state logic for the FSM and the accumulator/count/overflow registers.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_ACC: begin
        if (beat_s) begin
          acc_d = acc_next_s;
          cnt_d = sat_inc(cnt_q);
          ovf_d = ovf_q | wrap_s;
          if (i_last) begin
            state_d = S_OUT;
          end else begin
            state_d = S_ACC;
          end
        end else begin
          state_d = S_ACC;
        end
      end
      S_OUT: begin
        if (i_ready) begin
          // Result taken: start the next packet from a clean slate.
          acc_d   = 32'h0000_0000;
          cnt_d   = CNT_ZERO;
          ovf_d   = 1'b0;
          state_d = S_ACC;
        end else begin
          state_d = S_OUT;
        end
      end
      default: begin
        acc_d   = 32'h0000_0000;
        cnt_d   = CNT_ZERO;
        ovf_d   = 1'b0;
        state_d = S_ACC;
      end
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= S_ACC;
      acc_q   <= 32'h0000_0000;
      cnt_q   <= CNT_ZERO;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  // Output drive. Register values are forced to zero while reset is held, so
  // nothing undefined leaks out before the first reset edge.
  always_comb begin
    o_ready  = ready_s;
    o_valid  = i_rst_n && (state_q == S_OUT);
    if (beat_s) begin
      o_add_b = i_data;
    end else begin
      o_add_b = 32'h0000_0000;
    end
    if (i_rst_n) begin
      o_add_a  = acc_q;
      o_result = acc_q;
      o_count  = cnt_q;
      o_ovf    = ovf_q;
    end else begin
      o_add_a  = 32'h0000_0000;
      o_result = 32'h0000_0000;
      o_count  = CNT_ZERO;
      o_ovf    = 1'b0;
    end
  end

endmodule

// File: tb/tb_adder_accumulator_ctrl.sv
// Directed bench for adder_accumulator_ctrl. Two instances share the stimulus:
// the default CNT_W=8 and a CNT_W=2 copy for the count-saturation case. The
// external adder is modelled here as a plain 32-bit add.
module tb_adder_accumulator_ctrl;

  logic        clk;
  logic        rst_n;
  logic [31:0] data;
  logic        valid;
  logic        last;
  logic        rdy_in;

  logic        ready_o,  valid_o,  ovf_o;
  logic [31:0] add_a,    add_b,    sum,    result;
  logic [7:0]  count;

  logic        ready2_o, valid2_o, ovf2_o;
  logic [31:0] add_a2,   add_b2,   sum2,   result2;
  logic [1:0]  count2;

  int checks;
  int errors;

  assign sum  = add_a  + add_b;
  assign sum2 = add_a2 + add_b2;

  adder_accumulator_ctrl #(.CNT_W(8)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_data(data), .i_valid(valid), .i_last(last),
    .o_ready(ready_o), .o_add_a(add_a), .o_add_b(add_b), .i_add_sum(sum),
    .o_result(result), .o_count(count), .o_ovf(ovf_o), .o_valid(valid_o),
    .i_ready(rdy_in)
  );

  adder_accumulator_ctrl #(.CNT_W(2)) dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_data(data), .i_valid(valid), .i_last(last),
    .o_ready(ready2_o), .o_add_a(add_a2), .o_add_b(add_b2), .i_add_sum(sum2),
    .o_result(result2), .o_count(count2), .o_ovf(ovf2_o), .o_valid(valid2_o),
    .i_ready(rdy_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one beat for one edge, then drop valid/last.
  task automatic send(input logic [31:0] d, input logic l);
    valid = 1'b1;
    data  = d;
    last  = l;
    step();
    valid = 1'b0;
    last  = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    data   = 32'd123;
    valid  = 1'b1;
    last   = 1'b0;
    rdy_in = 1'b1;

    // Reset state; a valid beat under reset is not accepted.
    step();
    step();
    #1;
    check_eq("rst_ready",  32'(ready_o), 32'd0);
    check_eq("rst_valid",  32'(valid_o), 32'd0);
    check_eq("rst_result", result,       32'd0);
    check_eq("rst_count",  32'(count),   32'd0);
    check_eq("rst_ovf",    32'(ovf_o),   32'd0);
    check_eq("rst_add_a",  add_a,        32'd0);
    check_eq("rst_add_b",  add_b,        32'd0);
    valid = 1'b0;
    rst_n = 1'b1;
    #1;
    check_eq("rel_ready", 32'(ready_o), 32'd1);

    // Packet 5, 7, 9.
    valid = 1'b1; data = 32'd5; last = 1'b0;
    #1;
    check_eq("p1_add_b0", add_b, 32'd5);
    check_eq("p1_add_a0", add_a, 32'd0);
    step();
    data = 32'd7;
    #1;
    check_eq("p1_add_a1", add_a, 32'd5);
    step();
    data = 32'd9; last = 1'b1;
    #1;
    check_eq("p1_add_a2", add_a, 32'd12);
    check_eq("p1_valid_pre", 32'(valid_o), 32'd0);
    step();
    valid = 1'b0; last = 1'b0;
    #1;
    check_eq("p1_valid",  32'(valid_o), 32'd1);
    check_eq("p1_result", result,       32'd21);
    check_eq("p1_count",  32'(count),   32'd3);
    check_eq("p1_ovf",    32'(ovf_o),   32'd0);
    check_eq("p1_ready",  32'(ready_o), 32'd0);
    step();
    #1;
    check_eq("p1_ready_back", 32'(ready_o), 32'd1);
    check_eq("p1_valid_drop", 32'(valid_o), 32'd0);
    check_eq("p1_acc_clear",  result,       32'd0);

    // Overflow packet.
    send(32'hFFFF_FFF0, 1'b0);
    send(32'h0000_0020, 1'b1);
    #1;
    check_eq("ov_valid", 32'(valid_o), 32'd1);
    check_eq("ov_ovf",   32'(ovf_o),   32'd1);
    check_eq("ov_count", 32'(count),   32'd2);
`ifdef ACC_SAT_EN
    check_eq("ov_result", result, 32'hFFFF_FFFF);
`else
    check_eq("ov_result", result, 32'h0000_0010);
`endif
    step();
    #1;
    check_eq("ov_ovf_clear", 32'(ovf_o), 32'd0);

    // Single beat held under back-pressure; data toggling is ignored.
    rdy_in = 1'b0;
    send(32'hDEAD_BEEF, 1'b1);
    for (int i = 0; i < 4; i++) begin
      valid = 1'b1;
      data  = 32'h1111_1111 * (i + 1);
      last  = i[0];
      #1;
      check_eq("hold_valid",  32'(valid_o), 32'd1);
      check_eq("hold_result", result,       32'hDEAD_BEEF);
      check_eq("hold_count",  32'(count),   32'd1);
      check_eq("hold_ready",  32'(ready_o), 32'd0);
      check_eq("hold_add_b",  add_b,        32'd0);
      step();
    end
    valid = 1'b0; last = 1'b0; rdy_in = 1'b1;
    #1;
    check_eq("hold_release_valid", 32'(valid_o), 32'd1);
    step();
    #1;
    check_eq("hold_after_ready", 32'(ready_o), 32'd1);
    check_eq("hold_after_acc",   add_a,        32'd0);

    // Beats with idle gaps: 1, idle, 2, idle x3, 3 (last).
    send(32'd1, 1'b0);
    #1;
    check_eq("gap_add_b_idle1", add_b, 32'd0);
    check_eq("gap_add_a_idle1", add_a, 32'd1);
    step();
    send(32'd2, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq("gap_add_b_idle2", add_b, 32'd0);
      check_eq("gap_add_a_idle2", add_a, 32'd3);
      step();
    end
    send(32'd3, 1'b1);
    #1;
    check_eq("gap_valid",  32'(valid_o), 32'd1);
    check_eq("gap_result", result,       32'd6);
    check_eq("gap_count",  32'(count),   32'd3);
    step();

    // Five beats of 1: CNT_W=2 copy saturates its count at 3.
    for (int i = 0; i < 4; i++) begin
      send(32'd1, 1'b0);
    end
    send(32'd1, 1'b1);
    #1;
    check_eq("sat_count8",  32'(count),    32'd5);
    check_eq("sat_result8", result,        32'd5);
    check_eq("sat_valid2",  32'(valid2_o), 32'd1);
    check_eq("sat_count2",  32'(count2),   32'd3);
    check_eq("sat_result2", result2,       32'd5);
    check_eq("sat_ovf2",    32'(ovf2_o),   32'd0);
    step();

    // Reset after two beats discards the packet.
    send(32'd4, 1'b0);
    send(32'd4, 1'b0);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_ready", 32'(ready_o), 32'd0);
    check_eq("mid_rst_valid", 32'(valid_o), 32'd0);
    step();
    rst_n = 1'b1;
    #1;
    check_eq("mid_rst_valid_after", 32'(valid_o), 32'd0);
    check_eq("mid_rst_acc",         add_a,        32'd0);
    check_eq("mid_rst_count",       32'(count),   32'd0);
    step();
    #1;
    check_eq("mid_rst_valid_idle", 32'(valid_o), 32'd0);
    send(32'd4, 1'b1);
    #1;
    check_eq("post_rst_valid",  32'(valid_o), 32'd1);
    check_eq("post_rst_result", result,       32'd4);
    check_eq("post_rst_count",  32'(count),   32'd1);
    step();
    #1;
    check_eq("post_rst_done", 32'(valid_o), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
